// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, MDU freeze and branch flush control for IF/ID and ID/EX
//   clk, rst_n            : pipeline clock, async active-low reset
//   IFID_Rs/Rt/uses_rt    : source operands of the instruction in ID
//   IDEX_MemRead/IDEX_Rt  : load in EX and its destination
//   branch_taken          : taken branch resolved in EX
//   mdu_start             : MDU op entered EX (1-cycle pulse)
//   PCWrite/IFIDWrite     : PC and IF/ID load enables
//   IFID_Flush/IDEX_Bubble: NOP insertion into IF/ID and ID/EX
//   mdu_busy              : pipeline frozen for an MDU op
//   stall_cycles          : saturating count of cycles with IFIDWrite=0
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  IFID_uses_rt,
    input  logic                  IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt,
    input  logic                  branch_taken,
    input  logic                  mdu_start,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFID_Flush,
    output logic                  IDEX_Bubble,
    output logic                  mdu_busy,
    output logic [CNT_W-1:0]      stall_cycles
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_BUSY = 1'b1;
    localparam logic [3:0] LAT_M1   = 4'(MDU_LATENCY - 1);
    logic [0:0] state;
    logic [3:0] cnt;
    logic       luh;
    assign luh = IDEX_MemRead & (IDEX_Rt != '0) &
                 ((IDEX_Rt == IFID_Rs) | (IFID_uses_rt & (IDEX_Rt == IFID_Rt)));
    // Outputs are gated by rst_n so the pipeline is held safe while in reset.
    // A taken branch outranks luh: the stalled instruction is on the wrong path.
    always_comb begin
        mdu_busy    = rst_n & (state == MDU_BUSY);
        IFID_Flush  = rst_n & ~mdu_busy & branch_taken;
        PCWrite     = rst_n & ~mdu_busy & (branch_taken | ~luh);
        IFIDWrite   = PCWrite;
        IDEX_Bubble = ~rst_n | mdu_busy | branch_taken | luh;
    end
    // cnt runs LATENCY-1 down to 0 giving exactly MDU_LATENCY frozen cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (mdu_start && !branch_taken) begin
                state <= MDU_BUSY;
                cnt   <= LAT_M1;
            end
        end else begin
            state <= (cnt == '0) ? RUN : MDU_BUSY;
            cnt   <= (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (!IFIDWrite && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule
